// File: rtl/fdiv_finv_seq.sv
// Single-precision divide sequencer: x / y computed as x * finv(y).
// Drives the finv operand, waits the fixed finv latency, then multiplies and normalises.
module fdiv_finv_seq #(
  parameter int FINV_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] finv_a,
  input  logic [31:0] finv_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  localparam int CW = $clog2(FINV_LATENCY + 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid and its payload stay stable until that edge.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    MUL  = 3'd2,
    NORM = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]     cnt;
  logic [22:0]       x_man;
  logic [7:0]        x_exp;
  logic              sign;
  logic              nan_f, inf_f, zero_f;
  logic [47:0]       prod;
  logic signed [9:0] esum;
  logic signed [9:0] e_norm;
  logic [22:0]       mant;
  logic [31:0]       norm_res;
  logic              unused_finv_sign;

  // The reciprocal's sign is ignored; the quotient sign comes from x and y.
  assign unused_finv_sign = finv_result[31];

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = WAIT;
      WAIT: if (cnt <= CW'(1)) state_next = MUL;
      MUL:  state_next = NORM;
      NORM: state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Normalisation of the registered product; truncates, never rounds.
  always_comb begin
    mant   = prod[45:23];
    e_norm = esum - 10'sd127;
    if (prod[47]) begin
      mant   = prod[46:24];
      e_norm = esum - 10'sd126;
    end
    if (nan_f)                norm_res = 32'h7FC0_0000;
    else if (inf_f)           norm_res = {sign, 8'hFF, 23'h0};
    else if (zero_f)          norm_res = {sign, 31'h0};
    else if (e_norm <= 10'sd0)   norm_res = {sign, 31'h0};
    else if (e_norm >= 10'sd255) norm_res = {sign, 8'hFF, 23'h0};
    else                      norm_res = {sign, e_norm[7:0], mant};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      x_man     <= '0;
      x_exp     <= '0;
      sign      <= 1'b0;
      nan_f     <= 1'b0;
      inf_f     <= 1'b0;
      zero_f    <= 1'b0;
      prod      <= '0;
      esum      <= '0;
      finv_a    <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          finv_a <= y;
          x_man  <= x[22:0];
          x_exp  <= x[30:23];
          sign   <= x[31] ^ y[31];
          nan_f  <= (&x[30:23]) | (&y[30:23]);
          inf_f  <= (y[30:23] == 8'h00);
          zero_f <= (x[30:23] == 8'h00);
          cnt    <= CW'(FINV_LATENCY);
        end
        WAIT: if (cnt != '0) cnt <= cnt - CW'(1);
        MUL: begin
          // finv_result is valid on exactly this edge.
          prod <= 48'({1'b1, x_man}) * 48'({1'b1, finv_result[22:0]});
          esum <= $signed({2'b00, x_exp}) + $signed({2'b00, finv_result[30:23]});
        end
        NORM: begin
          result    <= norm_res;
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_finv_seq.sv
// Bench for fdiv_finv_seq: scripted finv stand-in plus a plain-arithmetic divide model.
module tb_fdiv_finv_seq;
  localparam int FINV_LATENCY = 4;
  localparam int EXP_LAT = FINV_LATENCY + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic [31:0] finv_result;
  logic        in_ready, out_valid, busy;
  logic [31:0] finv_a, result;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  fdiv_finv_seq #(.FINV_LATENCY(FINV_LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .finv_a(finv_a), .finv_result(finv_result),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // finv stand-in: the scripted reciprocal is presented only in the cycle
  // ending FINV_LATENCY+1 edges after the accept edge; junk otherwise.
  logic [31:0] script_inv = '0;
  logic [31:0] junk = 32'h1234_5678;
  int fc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fc <= 0;
    else if (in_valid && in_ready) fc <= 1;
    else if (fc != 0 && fc < FINV_LATENCY + 2) fc <= fc + 1;
    else fc <= 0;
  end
  assign finv_result = (fc == FINV_LATENCY + 1) ? script_inv : junk;

  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] r);
    logic s;
    int ea, eb, er, e;
    longint p;
    logic [22:0] m;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    er = int'(r[30:23]);
    if (ea == 255 || eb == 255) return 32'h7FC0_0000;
    if (eb == 0) return {s, 8'hFF, 23'h0};
    if (ea == 0) return {s, 31'h0};
    p = longint'({1'b1, a[22:0]}) * longint'({1'b1, r[22:0]});
    e = ea + er - 127;
    if (p >= (longint'(1) << 47)) begin
      e = e + 1;
      m = 23'(p >> 24);
    end else begin
      m = 23'(p >> 23);
    end
    if (e <= 0) return {s, 31'h0};
    if (e >= 255) return {s, 8'hFF, 23'h0};
    return {s, 8'(e), m};
  endfunction

  // One complete operation: accept, latency, result, optional stall, handshake.
  task automatic do_op(input logic [31:0] xv, input logic [31:0] yv, input logic [31:0] iv,
                       input int hold, input bit pulse_at_hs, input string tag);
    int g;
    int lat;
    logic [31:0] e_res;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s in_ready_wait: got %b want 1", tag, in_ready);
    end
    x = xv;
    y = yv;
    script_inv = iv;
    junk = $urandom;
    if (junk == iv) junk = ~iv;
    in_valid = 1'b1;
    exp_q.push_back(ref_div(xv, yv, iv));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = $urandom;
    y = $urandom;
    n_cmp++;
    if (finv_a !== yv || busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s accept: finv_a=%h busy=%b want %h 1", tag, finv_a, busy, yv);
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_cmp++;
    if (lat !== EXP_LAT) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, EXP_LAT);
    end
    e_res = exp_q.pop_front();
    n_cmp++;
    if (result !== e_res) begin
      n_err++;
      $display("FAIL %s result: got %h want %h (x=%h y=%h inv=%h)", tag, result, e_res, xv, yv, iv);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      x = $urandom;
      y = $urandom;
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || result !== e_res || finv_a !== yv || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s stall%0d: ov=%b res=%h fa=%h rdy=%b want 1 %h %h 0",
                 tag, i, out_valid, result, finv_a, in_ready, e_res, yv);
      end
    end
    @(negedge clk);
    in_valid = pulse_at_hs;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s handshake: ov=%b rdy=%b busy=%b want 0 1 0", tag, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || result !== 32'h0 || finv_a !== 32'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset: ov=%b res=%h fa=%h busy=%b rdy=%b want 0 0 0 0 1",
               out_valid, result, finv_a, busy, in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    do_op(32'h40C0_0000, 32'h4000_0000, 32'h3F00_0000, 0, 1'b0, "div6by2");
    do_op(32'hBF80_0000, 32'h0000_0000, 32'h3F80_0000, 0, 1'b0, "div_by_zero");
    do_op(32'h7F80_0000, 32'h3F80_0000, 32'h3F80_0000, 0, 1'b0, "nan_inf_x");
    do_op(32'h7F00_0000, 32'h3E80_0000, 32'h4080_0000, 0, 1'b0, "overflow");
    do_op(32'h0080_0000, 32'h4080_0000, 32'h3E80_0000, 0, 1'b0, "underflow");
  endtask

  task automatic test_stall();
    do_op(32'hC0A0_0000, 32'h4040_0000, 32'h3EAA_AAAB, 5, 1'b1, "stall");
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    x = 32'h4100_0000;
    y = 32'h4000_0000;
    script_inv = 32'h3F00_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || result !== 32'h0 || finv_a !== 32'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset: ov=%b res=%h fa=%h busy=%b rdy=%b want 0 0 0 0 1",
               out_valid, result, finv_a, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL stale_valid: got %b want 0", out_valid);
      end
    end
    do_op(32'h4100_0000, 32'h4000_0000, 32'h3F00_0000, 0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic [31:0] xv, yv, iv;
    int sel;
    for (int n = 0; n < 25; n++) begin
      xv = $urandom;
      yv = $urandom;
      iv = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) xv[30:23] = 8'h00;
      else if (sel == 1) yv[30:23] = 8'hFF;
      else if (sel == 2) yv[30:23] = 8'h00;
      else begin
        xv[30:23] = 8'($urandom_range(1, 254));
        yv[30:23] = 8'($urandom_range(1, 254));
      end
      iv[30:23] = 8'($urandom_range(1, 254));
      do_op(xv, yv, iv, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
